// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state type, default sizes and slot-width helper for the TDM demux
package tdm_pkg;
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  localparam int WIDTH_DEF = 4;
  localparam int NCH_DEF = 4;
  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-NCH slot index with enable, clear-to-0, load-to-1 and wrap flag
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SW = slot_w(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          load_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          wrap_o
);
  logic [SW-1:0] slot_q, slot_d;
  assign wrap_o = slot_q == SW'(NCH - 1);
  assign slot_o = slot_q;
  // clear beats load beats count; wrap back to 0 after the last slot
  always_comb
    slot_d = clr_i ? '0 : load_i ? SW'(1) : en_i ? (wrap_o ? '0 : slot_q + 1'b1) : slot_q;
  // slot register, async reset to slot 0
  always_ff @(posedge clk or posedge reset)
    if (reset) slot_q <= '0;
    else slot_q <= slot_d;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM receive demux, sync-aligned, atomic frame publish; TDM_DEMUX_SYNC_CHECK_EN enables sync checking
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH = NCH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic [WIDTH-1:0]     d,
  output logic [NCH*WIDTH-1:0] q,
  output logic                 valid,
  output logic                 locked,
  output logic                 err
);
  localparam int SW = slot_w(NCH);
  state_t state_q, state_d;
  logic [NCH-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [NCH*WIDTH-1:0] frame_q, frame_d;
  logic valid_q, valid_d, err_q, err_d;
  logic [SW-1:0] slot;
  logic wrap, take, miss, early, start, step;
  tdm_slot_counter #(.NCH(NCH), .SW(SW)) u_cnt (
    .clk(clk),
    .reset(reset),
    .en_i(step),
    .load_i(start),
    .clr_i(miss),
    .slot_o(slot),
    .wrap_o(wrap)
  );
  // decode the slot event, then steer d into shadow or publish the whole frame
  always_comb begin
    take = en && state_q == LOCKED;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    miss = take && slot == '0 && !sync;
    early = take && sync && slot != '0;
`else
    miss = 1'b0;
    early = 1'b0;
`endif
    start = (en && sync && state_q == UNLOCKED) || early;
    step = take && !miss && !early;
    shadow_d = shadow_q;
    if (start) shadow_d[0] = d;
    else if (step) shadow_d[slot] = d;
    frame_d = (step && wrap) ? {d, shadow_q[NCH-2:0]} : frame_q;
    valid_d = step && wrap;
    err_d = miss || early;
    state_d = start ? LOCKED : miss ? UNLOCKED : state_q;
  end
  // FSM state and registered outputs; reset discards any partial frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= UNLOCKED;
      shadow_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign q = frame_q;
  assign valid = valid_q;
  assign locked = state_q == LOCKED;
  assign err = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4 (WIDTH=4, NCH=4)
module tb_tdm_demux4;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, sync = 1'b0;
  logic [3:0] d = '0;
  logic [15:0] q;
  logic valid, locked, err;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  tdm_demux4 dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync(sync),
    .d(d),
    .q(q),
    .valid(valid),
    .locked(locked),
    .err(err)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic slot(input logic [3:0] v, input logic s);
    @(negedge clk);
    en = 1'b1;
    d = v;
    sync = s;
    @(posedge clk);
    #1;
    en = 1'b0;
    sync = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    #2;
    check("rst_q", q, 16'h0000);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_locked", 16'(locked), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    // lock and back-to-back frames
    slot(4'hA, 1'b1);
    check("t1_locked", 16'(locked), 16'h1);
    check("t1_q0", q, 16'h0000);
    slot(4'hB, 1'b0);
    slot(4'hC, 1'b0);
    check("t1_valid_early", 16'(valid), 16'h0);
    slot(4'hD, 1'b0);
    check("t1_q", q, 16'hDCBA);
    check("t1_valid", 16'(valid), 16'h1);
    slot(4'hE, 1'b1);
    check("t1_valid_drop", 16'(valid), 16'h0);
    check("t1_q_hold", q, 16'hDCBA);
    slot(4'hF, 1'b0);
    slot(4'h0, 1'b0);
    slot(4'h1, 1'b0);
    check("t1_q2", q, 16'h10FE);
    check("t1_valid2", 16'(valid), 16'h1);
    // gapped strobe
    do_reset();
    slot(4'hA, 1'b1);
    idle(2);
    check("t2_gap_valid", 16'(valid), 16'h0);
    slot(4'hB, 1'b0);
    idle(2);
    slot(4'hC, 1'b0);
    check("t2_q_hold0", q, 16'h0000);
    idle(2);
    check("t2_locked", 16'(locked), 16'h1);
    slot(4'hD, 1'b0);
    check("t2_q", q, 16'hDCBA);
    check("t2_valid", 16'(valid), 16'h1);
    idle(1);
    check("t2_valid_drop", 16'(valid), 16'h0);
    check("t2_q_keep", q, 16'hDCBA);
    // data before sync
    do_reset();
    slot(4'h1, 1'b0);
    check("t3_unlocked1", 16'(locked), 16'h0);
    slot(4'h2, 1'b0);
    check("t3_unlocked2", 16'(locked), 16'h0);
    slot(4'h5, 1'b1);
    check("t3_locked", 16'(locked), 16'h1);
    slot(4'h6, 1'b0);
    slot(4'h7, 1'b0);
    slot(4'h8, 1'b0);
    check("t3_q", q, 16'h8765);
    check("t3_valid", 16'(valid), 16'h1);
    // early sync
    do_reset();
    slot(4'h1, 1'b1);
    slot(4'h2, 1'b0);
    slot(4'h3, 1'b1);
    check("t4_err", 16'(err), 16'(CHK));
    check("t4_locked", 16'(locked), 16'h1);
    slot(4'h4, 1'b0);
    check("t4_err_drop", 16'(err), 16'h0);
    check("t4_valid_at4", 16'(valid), CHK ? 16'h0 : 16'h1);
    slot(4'h5, 1'b0);
    slot(4'h6, 1'b0);
    check("t4_q", q, CHK ? 16'h6543 : 16'h4321);
    check("t4_valid_at6", 16'(valid), CHK ? 16'h1 : 16'h0);
    // missing sync
    do_reset();
    slot(4'h1, 1'b1);
    slot(4'h2, 1'b0);
    slot(4'h3, 1'b0);
    slot(4'h4, 1'b0);
    check("t5_q1", q, 16'h4321);
    slot(4'h9, 1'b0);
    check("t5_err", 16'(err), 16'(CHK));
    check("t5_locked", 16'(locked), CHK ? 16'h0 : 16'h1);
    check("t5_q_keep", q, 16'h4321);
    slot(4'hA, 1'b1);
    check("t5_relock", 16'(locked), 16'h1);
    slot(4'hB, 1'b0);
    slot(4'hC, 1'b0);
    check("t5_q_mid", q, CHK ? 16'h4321 : 16'hCBA9);
    slot(4'hD, 1'b0);
    check("t5_q2", q, CHK ? 16'hDCBA : 16'hCBA9);
    // async reset mid-frame
    do_reset();
    slot(4'h1, 1'b1);
    slot(4'h2, 1'b0);
    slot(4'h3, 1'b0);
    slot(4'h4, 1'b0);
    slot(4'h5, 1'b1);
    slot(4'h6, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("t6_q", q, 16'h0000);
    check("t6_locked", 16'(locked), 16'h0);
    check("t6_valid", 16'(valid), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    slot(4'h7, 1'b1);
    slot(4'h8, 1'b0);
    slot(4'h9, 1'b0);
    check("t6_q_partial", q, 16'h0000);
    slot(4'hA, 1'b0);
    check("t6_q_fresh", q, 16'hA987);
    check("t6_valid_fresh", 16'(valid), 16'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
